// File: rtl/rr_csr_pkg.sv
// Shared constants and FSM state types for the record/replay CSR bank.
package rr_csr_pkg;

  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;
  localparam logic [31:0] CSR_POISON      = 32'hDEADBEEF;

  // state  | meaning
  // W_IDLE | collecting AW and W beats (either order)
  // W_RESP | write committed, B response pending bready
  typedef enum logic {W_IDLE, W_RESP} wr_state_e;

  // state  | meaning
  // R_IDLE | ready to accept AR
  // R_RESP | R beat registered, waiting for rready
  typedef enum logic {R_IDLE, R_RESP} rd_state_e;

endpackage

// File: rtl/rr_axil_wr_join.sv
// AXI-Lite write-channel join: accepts AW and W independently, holds
// whichever arrives first, and emits one commit strobe once both are present.
// Also owns the B channel; the response code is supplied by the decoder
// combinationally from the commit address.
module rr_axil_wr_join
  import rr_csr_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        init_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [31:0] awaddr_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic        bvalid_o,
  input  logic        bready_i,
  output logic [1:0]  bresp_o,
  input  logic [1:0]  resp_i,
  output logic        commit_o,
  output logic [31:0] commit_addr_o,
  output logic [31:0] commit_data_o,
  output logic [3:0]  commit_strb_o
);

  wr_state_e   state_q, state_d;
  logic        aw_held_q, aw_held_d;
  logic        w_held_q, w_held_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        aw_hs, w_hs;

  // Handshakes and the commit strobe; a held beat takes priority over the bus.
  always_comb begin
    awready_o     = (state_q == W_IDLE) && init_i && !aw_held_q;
    wready_o      = (state_q == W_IDLE) && init_i && !w_held_q;
    aw_hs         = awvalid_i && awready_o;
    w_hs          = wvalid_i && wready_o;
    commit_o      = (state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    commit_addr_o = aw_held_q ? awaddr_q : awaddr_i;
    commit_data_o = w_held_q ? wdata_q : wdata_i;
    commit_strb_o = w_held_q ? wstrb_q : wstrb_i;
    bvalid_o      = (state_q == W_RESP);
    bresp_o       = bresp_q;
  end

  // Next-state: hold beats until both are present, then respond on B.
  always_comb begin
    state_d   = state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    case (state_q)
      W_IDLE: begin
        if (commit_o) begin
          state_d   = W_RESP;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bresp_d   = resp_i;
        end else begin
          if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = awaddr_i;
          end
          if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = wdata_i;
            wstrb_d  = wstrb_i;
          end
        end
      end
      W_RESP: begin
        if (bready_i) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

  // State and holding registers; reset drops any half-collected write.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= AXI_RESP_OKAY;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end

endmodule

// File: rtl/rr_csr_axil_slave.sv
// AXI-Lite CSR bank for the record/replay logic: NUM_RW_REGS read-write
// words followed by NUM_RO_REGS read-only status words.
// Build option RR_CSR_DECERR_EN: out-of-range accesses answer DECERR
// (reads return CSR_POISON); otherwise they answer OKAY, reads return 0 and
// writes are dropped.
module rr_csr_axil_slave
  import rr_csr_pkg::*;
#(
  parameter int          NUM_RW_REGS  = 8,
  parameter int          NUM_RO_REGS  = 8,
  parameter logic [31:0] RW_RESET_VAL = 32'h0
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      axil_awvalid_i,
  output logic                      axil_awready_o,
  input  logic [31:0]               axil_awaddr_i,
  input  logic                      axil_wvalid_i,
  output logic                      axil_wready_o,
  input  logic [31:0]               axil_wdata_i,
  input  logic [3:0]                axil_wstrb_i,
  output logic                      axil_bvalid_o,
  input  logic                      axil_bready_i,
  output logic [1:0]                axil_bresp_o,
  input  logic                      axil_arvalid_i,
  output logic                      axil_arready_o,
  input  logic [31:0]               axil_araddr_i,
  output logic                      axil_rvalid_o,
  input  logic                      axil_rready_i,
  output logic [31:0]               axil_rdata_o,
  output logic [1:0]                axil_rresp_o,
  output logic [NUM_RW_REGS*32-1:0] csr_rw_q_o,
  output logic [NUM_RW_REGS-1:0]    csr_wr_pulse_o,
  input  logic [NUM_RO_REGS*32-1:0] csr_ro_d_i
);

  localparam int NUM_REGS = NUM_RW_REGS + NUM_RO_REGS;

  logic                             init_q;
  logic [NUM_RW_REGS-1:0][31:0]     csr_q, csr_d;
  logic [NUM_RW_REGS-1:0]           pulse_q, pulse_d;

  logic        commit;
  logic [31:0] commit_addr, commit_data;
  logic [3:0]  commit_strb;
  logic [29:0] wr_idx;
  logic [1:0]  wr_resp;

  rd_state_e   rd_state_q, rd_state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [29:0] rd_idx;
  logic [31:0] rd_word;
  logic [1:0]  rd_resp;
  logic        ar_hs;

  // Byte offset bits carry no meaning in a word-addressed bank.
  logic        unused_addr_lsbs;
  assign unused_addr_lsbs = ^{commit_addr[1:0], axil_araddr_i[1:0]};

  // Ready outputs stay low for the first cycle out of reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) init_q <= 1'b0;
    else         init_q <= 1'b1;
  end

  rr_axil_wr_join u_wr_join (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .init_i        (init_q),
    .awvalid_i     (axil_awvalid_i),
    .awready_o     (axil_awready_o),
    .awaddr_i      (axil_awaddr_i),
    .wvalid_i      (axil_wvalid_i),
    .wready_o      (axil_wready_o),
    .wdata_i       (axil_wdata_i),
    .wstrb_i       (axil_wstrb_i),
    .bvalid_o      (axil_bvalid_o),
    .bready_i      (axil_bready_i),
    .bresp_o       (axil_bresp_o),
    .resp_i        (wr_resp),
    .commit_o      (commit),
    .commit_addr_o (commit_addr),
    .commit_data_o (commit_data),
    .commit_strb_o (commit_strb)
  );

  assign wr_idx = commit_addr[31:2];

`ifdef RR_CSR_DECERR_EN
  assign wr_resp = (wr_idx < 30'(NUM_REGS)) ? AXI_RESP_OKAY : AXI_RESP_DECERR;
`else
  assign wr_resp = AXI_RESP_OKAY;
`endif

  // Byte-lane merge of a committed write; RO and out-of-range indices match no register.
  always_comb begin
    csr_d   = csr_q;
    pulse_d = '0;
    for (int i = 0; i < NUM_RW_REGS; i++) begin
      if (commit && (wr_idx == 30'(i))) begin
        pulse_d[i] = 1'b1;
        for (int b = 0; b < 4; b++) begin
          if (commit_strb[b]) csr_d[i][8*b +: 8] = commit_data[8*b +: 8];
        end
      end
    end
  end

  // RW storage and commit strobes.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      csr_q   <= {NUM_RW_REGS{RW_RESET_VAL}};
      pulse_q <= '0;
    end else begin
      csr_q   <= csr_d;
      pulse_q <= pulse_d;
    end
  end

  assign csr_rw_q_o     = csr_q;
  assign csr_wr_pulse_o = pulse_q;

  assign rd_idx = axil_araddr_i[31:2];

  // Read mux; uses csr_q (pre-write) so a same-edge write is not visible.
  always_comb begin
    rd_word = '0;
    rd_resp = AXI_RESP_OKAY;
    for (int i = 0; i < NUM_RW_REGS; i++) begin
      if (rd_idx == 30'(i)) rd_word = csr_q[i];
    end
    for (int j = 0; j < NUM_RO_REGS; j++) begin
      if (rd_idx == 30'(NUM_RW_REGS + j)) rd_word = csr_ro_d_i[32*j +: 32];
    end
`ifdef RR_CSR_DECERR_EN
    if (!(rd_idx < 30'(NUM_REGS))) begin
      rd_word = CSR_POISON;
      rd_resp = AXI_RESP_DECERR;
    end
`endif
  end

  // Read FSM next-state and R-channel outputs.
  always_comb begin
    rd_state_d     = rd_state_q;
    rdata_d        = rdata_q;
    rresp_d        = rresp_q;
    axil_arready_o = (rd_state_q == R_IDLE) && init_q;
    axil_rvalid_o  = (rd_state_q == R_RESP);
    axil_rdata_o   = rdata_q;
    axil_rresp_o   = rresp_q;
    ar_hs          = axil_arvalid_i && axil_arready_o;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rd_state_d = R_RESP;
          rdata_d    = rd_word;
          rresp_d    = rd_resp;
        end
      end
      R_RESP: begin
        if (axil_rready_i) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read FSM state and registered R beat.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_state_q <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= AXI_RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule
